// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle ADD/SUB/logic/shift ops, with an optional
// shift-add multiplier that is compiled in only when ALU_SEQ_MUL_EN is defined.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             error
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b111;
`endif

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state;
  logic   accept;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   shl_ext;
  logic [WIDTH:0]   shr_ext;
  logic [WIDTH-1:0] c_result;
  logic             c_carry;
  logic             c_overflow;
  logic             c_error;

  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // One extra bit on each shifter holds the last bit shifted out.
  assign sum     = {1'b0, a} + {1'b0, b};
  assign diff    = {1'b0, a} - {1'b0, b};
  assign shamt   = b[SHW-1:0];
  assign shl_ext = {1'b0, a} << shamt;
  assign shr_ext = {a, 1'b0} >> shamt;

  always_comb begin
    c_result   = '0;
    c_carry    = 1'b0;
    c_overflow = 1'b0;
    c_error    = 1'b0;
    case (op)
      OP_ADD: begin
        c_result   = sum[WIDTH-1:0];
        c_carry    = sum[WIDTH];
        c_overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        c_result   = diff[WIDTH-1:0];
        c_carry    = diff[WIDTH];
        c_overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: c_result = a & b;
      OP_OR:  c_result = a | b;
      OP_XOR: c_result = a ^ b;
      OP_SHL: begin
        c_result = shl_ext[WIDTH-1:0];
        c_carry  = shl_ext[WIDTH];
      end
      OP_SHR: begin
        c_result = shr_ext[WIDTH:1];
        c_carry  = shr_ext[0];
      end
      default: begin
`ifndef ALU_SEQ_MUL_EN
        c_error = 1'b1;
`endif
      end
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [CW-1:0]      count;

  assign acc_next = acc + (mplier[0] ? mcand : '0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      error     <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      count     <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
`ifdef ALU_SEQ_MUL_EN
            if (op == OP_MUL) begin
              mcand     <= {{WIDTH{1'b0}}, a};
              mplier    <= b;
              acc       <= '0;
              count     <= '0;
              state     <= BUSY;
              out_valid <= 1'b0;
            end else begin
`else
            begin
`endif
              result    <= c_result;
              zero      <= (c_result == '0);
              carry     <= c_carry;
              overflow  <= c_overflow;
              error     <= c_error;
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end else if ((state == DONE) && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
`ifdef ALU_SEQ_MUL_EN
        // One partial product per cycle; the last step lands on edge WIDTH after acceptance.
        BUSY: begin
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          acc    <= acc_next;
          count  <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) begin
            result    <= acc_next[WIDTH-1:0];
            zero      <= (acc_next[WIDTH-1:0] == '0);
            carry     <= |acc_next[2*WIDTH-1:WIDTH];
            overflow  <= 1'b0;
            error     <= 1'b0;
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
`endif
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed corner cases plus randomized traffic against
// an arithmetic reference model; follows ALU_SEQ_MUL_EN the same way the design does.
module tb_alu_seq;

  localparam int     WIDTH = 8;
  localparam longint MOD   = 64'sd1 <<< WIDTH;
  localparam longint SHMOD = 64'sd1 <<< $clog2(WIDTH);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [2:0]       op = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             overflow;
  logic             error;

  typedef struct {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             overflow;
    logic             error;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails = 0;
  bit   rand_ready = 1'b0;

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .carry(carry), .overflow(overflow), .error(error)
  );

  always #5 clk = ~clk;

  function automatic longint to_signed(input longint u);
    return (u >= MOD / 2) ? u - MOD : u;
  endfunction

  function automatic exp_t model(input logic [2:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    exp_t   e;
    longint ux = longint'(x);
    longint uy = longint'(y);
    longint full = 0;
    longint sh = uy % SHMOD;
    e.carry = 1'b0;
    e.overflow = 1'b0;
    e.error = 1'b0;
    case (o)
      3'd0: begin
        full = ux + uy;
        e.carry = (full >= MOD);
        e.overflow = ((to_signed(ux) + to_signed(uy)) > MOD / 2 - 1) || ((to_signed(ux) + to_signed(uy)) < -(MOD / 2));
      end
      3'd1: begin
        full = ux - uy + MOD;
        e.carry = (ux < uy);
        e.overflow = ((to_signed(ux) - to_signed(uy)) > MOD / 2 - 1) || ((to_signed(ux) - to_signed(uy)) < -(MOD / 2));
      end
      3'd2: full = ux & uy;
      3'd3: full = ux | uy;
      3'd4: full = ux ^ uy;
      3'd5: begin
        full = ux << sh;
        e.carry = (sh != 0) && (((full / MOD) % 2) == 1);
      end
      3'd6: begin
        full = ux >> sh;
        e.carry = (sh != 0) && (((ux >> (sh - 1)) % 2) == 1);
      end
      default: begin
`ifdef ALU_SEQ_MUL_EN
        full = ux * uy;
        e.carry = (full / MOD) != 0;
`else
        full = 0;
        e.error = 1'b1;
`endif
      end
    endcase
    e.result = WIDTH'(full % MOD);
    e.zero = (e.result == '0);
    return e;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic apply_stimulus(input logic [2:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    int guard = 0;
    op = o;
    a = x;
    b = y;
    in_valid = 1'b1;
    #1;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      #1;
      guard++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fails++;
      $display("[TB] FAIL accept_timeout: in_ready stayed 0 for op %0d", o);
    end else begin
      exp_q.push_back(model(o, x, y));
    end
    @(negedge clk);
    in_valid = 1'b0;
    op = 3'($urandom);
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
  endtask

  task automatic drain();
    int guard = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fails++;
      $display("[TB] FAIL drain_timeout: %0d results still pending", exp_q.size());
    end
    @(negedge clk);
  endtask

  // Monitor: every cycle a result is presented it must match the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("[TB] FAIL unexpected_result: out_valid with result 0x%0h and nothing pending", result);
        end else begin
          e = exp_q[0];
          check_output("mon_result", 32'(result), 32'(e.result));
          check_output("mon_zero", 32'(zero), 32'(e.zero));
          check_output("mon_carry", 32'(carry), 32'(e.carry));
          check_output("mon_overflow", 32'(overflow), 32'(e.overflow));
          check_output("mon_error", 32'(error), 32'(e.error));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int busy;
    int guard;
    int valid_seen;

    repeat (3) @(negedge clk);
    #1;
    check_output("reset_out_valid", 32'(out_valid), 32'd0);
    check_output("reset_result", 32'(result), 32'd0);
    check_output("reset_flags", 32'({zero, carry, overflow, error}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_output("in_ready_after_reset", 32'(in_ready), 32'd1);
    @(negedge clk);

    out_ready = 1'b1;
    apply_stimulus(3'd0, 8'hFF, 8'h01);
    #1;
    check_output("add_latency_valid", 32'(out_valid), 32'd1);
    check_output("add_ff_01_result", 32'(result), 32'h00);
    check_output("add_ff_01_flags", 32'({zero, carry, overflow}), 32'b110);
    @(negedge clk);

    apply_stimulus(3'd1, 8'h80, 8'h01);
    #1;
    check_output("sub_80_01_result", 32'(result), 32'h7F);
    check_output("sub_80_01_flags", 32'({carry, overflow}), 32'b01);
    @(negedge clk);

    apply_stimulus(3'd5, 8'h81, 8'h01);
    #1;
    check_output("shl_81_1_result", 32'(result), 32'h02);
    check_output("shl_81_1_carry", 32'(carry), 32'd1);
    @(negedge clk);

    apply_stimulus(3'd7, 8'h10, 8'h11);
    #1;
`ifdef ALU_SEQ_MUL_EN
    busy = 0;
    guard = 0;
    while (!out_valid && guard < 40) begin
      if (!in_ready) busy++;
      @(negedge clk);
      #1;
      guard++;
    end
    check_output("mul_busy_cycles", 32'(busy), 32'd8);
    check_output("mul_10_11_result", 32'(result), 32'h10);
    check_output("mul_10_11_carry", 32'(carry), 32'd1);
`else
    check_output("mul_disabled_valid", 32'(out_valid), 32'd1);
    check_output("mul_disabled_result", 32'(result), 32'h00);
    check_output("mul_disabled_flags", 32'({zero, carry, overflow, error}), 32'b1001);
`endif
    @(negedge clk);
    drain();

    out_ready = 1'b0;
    apply_stimulus(3'd0, 8'h03, 8'h04);
    for (int i = 0; i < 5; i++) begin
      #1;
      check_output("stall_valid", 32'(out_valid), 32'd1);
      check_output("stall_result", 32'(result), 32'h07);
      check_output("stall_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    apply_stimulus(3'd2, 8'hC5, 8'h3C);
    #1;
    check_output("b2b_and_valid", 32'(out_valid), 32'd1);
    check_output("b2b_and_result", 32'(result), 32'h04);
    @(negedge clk);
    drain();

`ifdef ALU_SEQ_MUL_EN
    out_ready = 1'b1;
    apply_stimulus(3'd7, 8'h23, 8'h45);
`else
    out_ready = 1'b0;
    apply_stimulus(3'd0, 8'h03, 8'h04);
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_output("midrun_reset_valid", 32'(out_valid), 32'd0);
    check_output("midrun_reset_result", 32'(result), 32'd0);
    check_output("midrun_reset_flags", 32'({zero, carry, overflow, error}), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check_output("midrun_in_ready", 32'(in_ready), 32'd1);
    valid_seen = 0;
    for (int i = 0; i < WIDTH + 4; i++) begin
      @(negedge clk);
      #1;
      if (out_valid) valid_seen++;
    end
    check_output("aborted_never_valid", 32'(valid_seen), 32'd0);
    @(negedge clk);

    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) @(negedge clk);
      apply_stimulus(3'($urandom_range(0, 7)), WIDTH'($urandom), WIDTH'($urandom));
    end
    rand_ready = 1'b0;
    drain();
    check_output("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
